// File: rtl/sync_evt_pkg.sv
// Shared definitions for the synchronized-event scheduler: FSM encoding and
// sizing helpers used by the top and the round-robin picker.
package sync_evt_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } sched_state_e;

  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic int id_w(input int evt_num);
    return (evt_num <= 2) ? 1 : $clog2(evt_num);
  endfunction

endpackage

// File: rtl/sync_evt_rr_arb.sv
// Combinational rotate-priority picker: first asserted request found by
// scanning from ptr_i upward, wrapping at N.
module sync_evt_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           gnt_vld_o,
  output logic [IDW-1:0] gnt_id_o
);

  int             idx;
  logic [IDW-1:0] sel;

  // Scan from the farthest offset down so the nearest hit to ptr_i wins last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_id_o  = '0;
    idx       = 0;
    sel       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = IDW'(idx);
      if (req_i[sel]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = sel;
      end
    end
  end

endmodule

// File: rtl/sync_evt_sched.sv
// Per-source saturating event queues served one at a time to a shared
// consumer over req/ack, round-robin between sources.
module sync_evt_sched
  import sync_evt_pkg::*;
#(
  parameter int  EVT_NUM = 4,
  parameter int  CNT_W   = 3,
  localparam int IDW     = id_w(EVT_NUM)
) (
  input  logic               cpuclk,
  input  logic               cpurst_b,
  input  logic [EVT_NUM-1:0] evt_pulse,
  input  logic [EVT_NUM-1:0] evt_en,
  output logic               sched_req,
  output logic [IDW-1:0]     sched_id,
  input  logic               sched_ack,
  output logic [EVT_NUM-1:0] pend_vld,
  output logic [EVT_NUM-1:0] ovf_flag,
  input  logic [EVT_NUM-1:0] ovf_clr,
  output logic               busy,
  output logic               dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  // Handshake: sched_req rises with sched_id stable and stays high until the
  // cycle sched_ack is sampled high; that cycle is the transfer. sched_ack
  // outside a request is ignored.
  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   sched_id_q, sched_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q [EVT_NUM];
  logic [CNT_W-1:0] cnt_d [EVT_NUM];
  logic [EVT_NUM-1:0] ovf_q, ovf_d, ovf_set;
  logic [EVT_NUM-1:0] inc_v, dec_v;
  logic               ack_acc;
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_id;

  assign ack_acc = (state_q == ST_REQ) && sched_ack;
  assign inc_v   = evt_pulse & evt_en;

  always_comb begin
    dec_v = '0;
    for (int i = 0; i < EVT_NUM; i++) begin
      dec_v[i] = ack_acc && (sched_id_q == IDW'(i));
    end
  end

  // A simultaneous arrival and service cancel out and never count as overflow.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < EVT_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_comb begin
    pend_vld = '0;
    for (int i = 0; i < EVT_NUM; i++) begin
      pend_vld[i] = (cnt_q[i] != '0);
    end
  end

  sync_evt_rr_arb #(
    .N   (EVT_NUM),
    .IDW (IDW)
  ) u_arb (
    .req_i     (pend_vld),
    .ptr_i     (rr_ptr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    sched_id_d = sched_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          sched_id_d = gnt_id;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sched_ack) begin
          rr_ptr_d = (sched_id_q == IDW'(EVT_NUM - 1)) ? '0 : sched_id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_IDLE;
      sched_id_q <= '0;
      rr_ptr_q   <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < EVT_NUM; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sched_id_q <= sched_id_d;
      rr_ptr_q   <= rr_ptr_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < EVT_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sched_req = (state_q == ST_REQ);
  assign sched_id  = sched_id_q;
  assign ovf_flag  = ovf_q;
  assign busy      = sched_req | (|pend_vld);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_evt_sched.sv
// Bench for sync_evt_sched: directed scenarios plus random traffic against a
// queue-count reference model, with a scoreboard on served source ids.
module tb_sync_evt_sched;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int IDW  = 2;
  localparam int MAXC = 7;

  logic           cpuclk;
  logic           cpurst_b;
  logic [N-1:0]   evt_pulse;
  logic [N-1:0]   evt_en;
  logic           sched_req;
  logic [IDW-1:0] sched_id;
  logic           sched_ack;
  logic [N-1:0]   pend_vld;
  logic [N-1:0]   ovf_flag;
  logic [N-1:0]   ovf_clr;
  logic           busy;
  logic           dbg_state;

  sync_evt_sched #(
    .EVT_NUM (N),
    .CNT_W   (CW)
  ) dut (
    .cpuclk    (cpuclk),
    .cpurst_b  (cpurst_b),
    .evt_pulse (evt_pulse),
    .evt_en    (evt_en),
    .sched_req (sched_req),
    .sched_id  (sched_id),
    .sched_ack (sched_ack),
    .pend_vld  (pend_vld),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    cpuclk = 1'b0;
    forever #5 cpuclk = ~cpuclk;
  end

  int checks   = 0;
  int failures = 0;

  logic [IDW-1:0] exp_q[$];

  // reference model: pending count per source, current request, pointer
  int       cnt_m [N];
  bit       req_m;
  int       id_m;
  int       ptr_m;
  bit [N-1:0] ovf_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pend_m();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (cnt_m[i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    req_m = 0;
    id_m  = 0;
    ptr_m = 0;
    ovf_m = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("sched_req", int'(sched_req), int'(req_m));
    chk("sched_id",  int'(sched_id),  id_m);
    chk("pend_vld",  int'(pend_vld),  int'(pend_m()));
    chk("ovf_flag",  int'(ovf_flag),  int'(ovf_m));
    chk("busy",      int'(busy),      int'(req_m || (pend_m() != '0)));
    chk("dbg_state", int'(dbg_state), int'(req_m));
  endtask

  // driver: called at posedge+1; applies inputs for one cycle and advances the model
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] e,
                      input logic [N-1:0] c, input logic a);
    int         ncnt [N];
    bit [N-1:0] nov;
    bit         nreq;
    int         nid, nptr;
    bit         acc, inc, dec;
    evt_pulse = p;
    evt_en    = e;
    ovf_clr   = c;
    sched_ack = a;
    acc  = req_m && a;
    nreq = req_m;
    nid  = id_m;
    nptr = ptr_m;
    if (req_m) begin
      if (a) begin
        exp_q.push_back(IDW'(id_m));
        nptr = (id_m + 1) % N;
        nreq = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr_m + k) % N;
        if (cnt_m[j] != 0) begin
          nid  = j;
          nreq = 1;
          break;
        end
      end
    end
    nov = ovf_m & ~c;
    for (int i = 0; i < N; i++) begin
      inc = p[i] && e[i];
      dec = acc && (id_m == i);
      ncnt[i] = cnt_m[i];
      if (inc && !dec) begin
        if (cnt_m[i] == MAXC) nov[i] = 1'b1;
        else                  ncnt[i] = cnt_m[i] + 1;
      end else if (dec && !inc) begin
        ncnt[i] = cnt_m[i] - 1;
      end
    end
    @(posedge cpuclk);
    #1;
    for (int i = 0; i < N; i++) cnt_m[i] = ncnt[i];
    ovf_m = nov;
    req_m = nreq;
    id_m  = nid;
    ptr_m = nptr;
    check_outputs();
  endtask

  task automatic step_rand(input int pulse_pct, input int ack_pct);
    logic [N-1:0] p, e, c;
    for (int i = 0; i < N; i++) begin
      p[i] = ($urandom_range(0, 99) < pulse_pct);
      c[i] = ($urandom_range(0, 9) == 0);
    end
    e = ($urandom_range(0, 3) == 0) ? N'($urandom) : {N{1'b1}};
    step(p, e, c, ($urandom_range(0, 99) < ack_pct));
  endtask

  // scoreboard monitor: every accepted transfer must match the next expected id
  always @(negedge cpuclk) begin
    if (cpurst_b && sched_req && sched_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected: got id %0d expected no transfer at %0t", sched_id, $time);
      end else begin
        logic [IDW-1:0] e;
        e = exp_q.pop_front();
        if (sched_id !== e) begin
          failures++;
          $display("FAIL grant_id: got %0d expected %0d at %0t", sched_id, e, $time);
        end
      end
    end
  end

  localparam logic [N-1:0] ALL = {N{1'b1}};
  localparam logic [N-1:0] NONE = '0;

  initial begin
    int guard;
    cpurst_b  = 1'b0;
    evt_pulse = '0;
    evt_en    = '0;
    ovf_clr   = '0;
    sched_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge cpuclk);
    #1;
    check_outputs();
    cpurst_b = 1'b1;
    step(NONE, ALL, NONE, 1'b0);

    // single pulse on src2, ack at first request
    step(4'b0100, ALL, NONE, 1'b1);
    repeat (4) step(NONE, ALL, NONE, 1'b1);

    // three sources pending together, acked immediately
    step(4'b1011, ALL, NONE, 1'b1);
    repeat (8) step(NONE, ALL, NONE, 1'b1);

    // saturate src1, then clear racing a fresh overflow, then drain
    repeat (8) step(4'b0010, ALL, NONE, 1'b0);
    step(4'b0010, ALL, 4'b0010, 1'b0);
    step(NONE, ALL, 4'b0010, 1'b0);
    repeat (18) step(NONE, ALL, NONE, 1'b1);

    // arrival on src0 in the cycle its last queued event is acked
    step(4'b0001, ALL, NONE, 1'b0);
    step(NONE, ALL, NONE, 1'b0);
    step(4'b0001, ALL, NONE, 1'b1);
    repeat (4) step(NONE, ALL, NONE, 1'b1);

    // disabled source drops pulses
    step(4'b1000, 4'b0111, NONE, 1'b1);
    repeat (3) step(NONE, 4'b0111, NONE, 1'b1);

    repeat (2000) step_rand(30, 50);
    repeat (300) step_rand(70, 15);

    // async reset in the middle of a handshake
    guard = 0;
    while (!req_m && guard < 50) begin
      step(4'b0110, ALL, NONE, 1'b0);
      guard++;
    end
    chk("req_before_reset", int'(req_m), 1);
    repeat (6) step(4'b0110, ALL, NONE, 1'b0);
    cpurst_b = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge cpuclk);
    cpurst_b  = 1'b1;
    evt_pulse = '0;
    sched_ack = 1'b0;
    @(posedge cpuclk);
    #1;
    check_outputs();

    repeat (500) step_rand(25, 60);

    // drain everything and make sure every predicted transfer was seen
    repeat (80) step(NONE, ALL, NONE, 1'b1);
    chk("drain_pend", int'(pend_vld), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
